// File: rtl/rx_frame_queue.sv
// Frame FIFO between the RX path and the controller: first-word-fall-through
// head, optional CRC-error discard, saturating overflow/drop statistics.
module rx_frame_queue #(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [LEN_W-1:0]             in_len,
    input  logic [ID_W-1:0]              in_sender,
    input  logic                         in_crc_err,
    input  logic                         drop_crc,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [LEN_W-1:0]             out_len,
    output logic [ID_W-1:0]              out_sender,
    output logic                         out_crc_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic [CNT_W-1:0]             ovf_cnt,
    output logic [CNT_W-1:0]             crc_drop_cnt,
    output logic                         ovf_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DATA_W + LEN_W + ID_W + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          pop;
    logic          acc;
    logic          push;
    logic          ovf;
    logic          crc_drop;

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));

    assign pop      = out_valid & out_ready;
    assign crc_drop = in_valid & in_crc_err & drop_crc;
    assign acc      = in_valid & ~(in_crc_err & drop_crc);
    // A pop frees the slot in the same cycle, so a full queue still accepts.
    assign push     = acc & (~full | pop);
    assign ovf      = acc & full & ~pop;

    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_data, out_len, out_sender, out_crc_err} = head;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_data, in_len, in_sender, in_crc_err};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ovf_cnt      <= '0;
            crc_drop_cnt <= '0;
            ovf_sticky   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (ovf) begin
                ovf_sticky <= 1'b1;
                if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                end
            end
            if (crc_drop && crc_drop_cnt != '1) begin
                crc_drop_cnt <= crc_drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_queue.sv
// Directed bench for rx_frame_queue: ordering, overflow, CRC drop,
// saturation, flush priority, pointer wrap and async reset.
module tb_rx_frame_queue;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_len;
    logic [1:0]   in_sender;
    logic         in_crc_err;
    logic         drop_crc;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_len;
    logic [1:0]   out_sender;
    logic         out_crc_err;
    logic [2:0]   count;
    logic         full;
    logic [7:0]   ovf_cnt;
    logic [7:0]   crc_drop_cnt;
    logic         ovf_sticky;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rx_frame_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_sender    (in_sender),
        .in_crc_err   (in_crc_err),
        .drop_crc     (drop_crc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_len      (out_len),
        .out_sender   (out_sender),
        .out_crc_err  (out_crc_err),
        .count        (count),
        .full         (full),
        .ovf_cnt      (ovf_cnt),
        .crc_drop_cnt (crc_drop_cnt),
        .ovf_sticky   (ovf_sticky)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [127:0] d, input logic [3:0] l,
                              input logic [1:0] s, input logic c);
        in_valid   = 1'b1;
        in_data    = d;
        in_len     = l;
        in_sender  = s;
        in_crc_err = c;
        tick();
        in_valid   = 1'b0;
        in_crc_err = 1'b0;
    endtask

    task automatic pop_frame;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_len     = '0;
        in_sender  = '0;
        in_crc_err = 1'b0;
        drop_crc   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_sticky", ovf_sticky, 0);
        rst_n = 1'b1;
        tick();

        // 1: single frame latency and fields
        push_frame(128'hA5, 4'd4, 2'd2, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 128'hA5);
        chk("t1_len", out_len, 4);
        chk("t1_sender", out_sender, 2);
        chk("t1_count", count, 1);
        pop_frame();
        chk("t1_empty", out_valid, 0);
        chk("t1_zero_data", out_data, 0);

        // 2: fill, overflow, ordered drain
        for (int i = 1; i <= 4; i++)
            push_frame(128'h10 + 128'(i), 4'(i), 2'(i), 1'b0);
        chk("t2_full", full, 1);
        chk("t2_count", count, 4);
        chk("t2_ovf0", ovf_cnt, 0);
        push_frame(128'h55, 4'd5, 2'd1, 1'b0);
        chk("t2_count_ovf", count, 4);
        chk("t2_ovf", ovf_cnt, 1);
        chk("t2_sticky", ovf_sticky, 1);
        tick();
        chk("t2_stable", out_data, 128'h11);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", out_data, 128'h10 + 128'(i));
            chk("t2_len", out_len, 4'(i));
            pop_frame();
        end
        chk("t2_drained", count, 0);
        chk("t2_sticky_kept", ovf_sticky, 1);

        // 3: push and pop together while full
        for (int i = 1; i <= 4; i++)
            push_frame(128'h20 + 128'(i), 4'(i), 2'd0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 128'h25;
        in_len    = 4'd9;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_ovf", ovf_cnt, 1);
        for (int i = 2; i <= 5; i++) begin
            chk("t3_order", out_data, 128'h20 + 128'(i));
            pop_frame();
        end
        chk("t3_empty", count, 0);

        // 4: CRC drop vs store
        drop_crc = 1'b1;
        push_frame(128'h77, 4'd7, 2'd3, 1'b1);
        chk("t4_count", count, 0);
        chk("t4_drop", crc_drop_cnt, 1);
        chk("t4_valid", out_valid, 0);
        drop_crc = 1'b0;
        push_frame(128'h78, 4'd8, 2'd3, 1'b1);
        chk("t4_stored", count, 1);
        chk("t4_crcflag", out_crc_err, 1);
        chk("t4_data", out_data, 128'h78);
        chk("t4_drop_kept", crc_drop_cnt, 1);
        pop_frame();

        // 5: overflow saturation
        for (int i = 1; i <= 4; i++)
            push_frame(128'h30 + 128'(i), 4'(i), 2'd1, 1'b0);
        for (int i = 0; i < 300; i++)
            push_frame(128'hEE, 4'd1, 2'd1, 1'b0);
        chk("t5_sat", ovf_cnt, 255);
        chk("t5_count", count, 4);
        drop_crc = 1'b1;
        push_frame(128'hEF, 4'd1, 2'd1, 1'b1);
        drop_crc = 1'b0;
        chk("t5_crc_full", crc_drop_cnt, 2);
        chk("t5_sat_hold", ovf_cnt, 255);

        // 6: flush with push, then wrap traffic
        pop_frame();
        chk("t6_three", count, 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'h99;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_sticky", ovf_sticky, 0);
        chk("t6_ovf_kept", ovf_cnt, 255);
        chk("t6_crc_kept", crc_drop_cnt, 2);
        push_frame(128'h100, 4'd0, 2'd0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            chk("t6_wrap", out_data, 128'h100 + 128'(k - 1));
            in_valid  = 1'b1;
            in_data   = 128'h100 + 128'(k);
            in_len    = 4'(k);
            out_ready = 1'b1;
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("t6_wrap_cnt", count, 1);
        end
        chk("t6_last", out_data, 128'h109);
        chk("t6_last_len", out_len, 9);
        pop_frame();
        chk("t6_end", count, 0);

        // async reset mid-traffic
        push_frame(128'hC1, 4'd1, 2'd1, 1'b0);
        push_frame(128'hC2, 4'd2, 2'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_ovf", ovf_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
